// File: rtl/pdp1_pkg.sv
// Shared definitions for the PDP-1 style tape reader.
// Reader FSM states and frame hole bit positions.
package pdp1_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ALPHA,
      BIN,
      DONE
   } rd_state_e;

   localparam int FEED    = 9;
   localparam int BINFLAG = 8;

endpackage

// File: rtl/frame_fifo.sv
// Read-ahead frame buffer for the tape reader.
// Circular, pointers one bit wider than the address.
module frame_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clr,
   input  logic                     push,
   input  logic                     pop,
   input  logic [7:0]               din,
   output logic [7:0]               dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [7:0]  mem_q [DEPTH];
   logic [7:0]  mem_d [DEPTH];
   logic [AW:0] wr_q, wr_d;
   logic [AW:0] rd_q, rd_d;

   assign count = wr_q - rd_q;
   assign full  = (count == (AW + 1)'(DEPTH));
   assign empty = (wr_q == rd_q);
   assign dout  = mem_q[rd_q[AW-1:0]];

   // Pointer and storage next-state; clear flushes by aligning pointers.
   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      mem_d = mem_q;
      if (clr) begin
         wr_d = '0;
         rd_d = '0;
      end else begin
         if (push) begin
            mem_d[wr_q[AW-1:0]] = din;
            wr_d = wr_q + 1'b1;
         end
         if (pop) begin
            rd_d = rd_q + 1'b1;
         end
      end
   end

   // Pointer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   // Frame storage; contents are don't-care until written.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/ptr_reader.sv
// Paper tape reader: synchronises holes, buffers frames,
// and assembles alphanumeric or binary words into rb.
module ptr_reader #(
   parameter int WORD_W     = 18,
   parameter int FRAME_BITS = 6,
   parameter int FRAMES     = 3,
   parameter int DEPTH      = 4,
   parameter int PREFETCH   = 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [9:1]                hole,
   input  logic                      clr,
   input  logic                      rpa,
   input  logic                      rpb,
   output logic [WORD_W-1:0]         rb,
   output logic                      rdone,
   output logic                      rcl,
   output logic                      busy,
   output logic                      overrun,
   output logic [$clog2(DEPTH):0]    count
);

   import pdp1_pkg::*;

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int KW = (FRAMES > 1) ? $clog2(FRAMES) : 1;

   rd_state_e          state_q, state_d;
   logic [WORD_W-1:0]  rb_q, rb_d;
   logic [KW-1:0]      k_q, k_d;
   logic               rdone_q, rdone_d;
   logic               overrun_q, overrun_d;
   logic [9:1]         s1_q, s2_q;
   logic               feed_q;
   logic               frame_ev;
   logic               push, pop;
   logic               full, empty;
   logic [7:0]         dout;
   logic [WORD_W-1:0]  ins;

   frame_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (reset),
      .clr   (clr),
      .push  (push),
      .pop   (pop),
      .din   (s2_q[BINFLAG:1]),
      .dout  (dout),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   assign frame_ev = s2_q[FEED] & ~feed_q;
   assign busy     = (state_q != IDLE);
   assign rcl      = (count < CW'(DEPTH - 1)) && (busy || (PREFETCH == 1));
   assign rb       = rb_q;
   assign rdone    = rdone_q;
   assign overrun  = overrun_q;

   // Frame capture: a frame on a full FIFO survives only if a pop frees a slot.
   always_comb begin
      push      = !clr && frame_ev && (!full || pop);
      overrun_d = overrun_q;
      if (clr) begin
         overrun_d = 1'b0;
      end else if (frame_ev && full && !pop) begin
         overrun_d = 1'b1;
      end
   end

   // Word assembly FSM; clear wins over requests and frames.
   always_comb begin
      state_d = state_q;
      rb_d    = rb_q;
      k_d     = k_q;
      pop     = 1'b0;
      rdone_d = 1'b0;
      ins     = '0;
      ins[FRAME_BITS-1:0] = dout[FRAME_BITS-1:0];
      if (clr) begin
         state_d = IDLE;
         rb_d    = '0;
         k_d     = '0;
      end else begin
         rdone_d = (state_q == DONE);
         unique case (state_q)
            IDLE: begin
               if (rpb) begin
                  rb_d    = '0;
                  k_d     = '0;
                  state_d = BIN;
               end else if (rpa) begin
                  rb_d    = '0;
                  state_d = ALPHA;
               end
            end
            ALPHA: begin
               if (!empty) begin
                  pop       = 1'b1;
                  rb_d      = '0;
                  rb_d[7:0] = dout;
                  state_d   = DONE;
               end
            end
            BIN: begin
               if (!empty) begin
                  pop = 1'b1;
                  if (dout[BINFLAG-1]) begin
                     rb_d = (rb_q << FRAME_BITS) | ins;
                     if (k_q == KW'(FRAMES - 1)) begin
                        k_d     = '0;
                        state_d = DONE;
                     end else begin
                        k_d = k_q + 1'b1;
                     end
                  end
               end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // State, synchroniser and edge-detect registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         rb_q      <= '0;
         k_q       <= '0;
         rdone_q   <= 1'b0;
         overrun_q <= 1'b0;
         s1_q      <= '0;
         s2_q      <= '0;
         feed_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         rb_q      <= rb_d;
         k_q       <= k_d;
         rdone_q   <= rdone_d;
         overrun_q <= overrun_d;
         s1_q      <= hole;
         s2_q      <= s1_q;
         feed_q    <= s2_q[FEED];
      end
   end

endmodule

// File: tb/tb_ptr_reader.sv
// Bench for ptr_reader: default build plus a 16-bit, 2x8 build.
// Expected words are derived from the frame lists directly.
module tb_ptr_reader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n;
   logic        clr;
   logic [9:1]  hole_a, hole_b;
   logic        rpa_a, rpb_a, rpa_b, rpb_b;
   logic [17:0] rb_a;
   logic [15:0] rb_b;
   logic        rdone_a, rcl_a, busy_a, overrun_a;
   logic        rdone_b, rcl_b, busy_b, overrun_b;
   logic [2:0]  count_a, count_b;

   int checks = 0;
   int errors = 0;
   int rd_a = 0;
   int rd_b = 0;

   ptr_reader u_a (
      .clk(clk), .reset(reset_n), .hole(hole_a), .clr(clr),
      .rpa(rpa_a), .rpb(rpb_a), .rb(rb_a), .rdone(rdone_a),
      .rcl(rcl_a), .busy(busy_a), .overrun(overrun_a), .count(count_a)
   );

   ptr_reader #(.WORD_W(16), .FRAME_BITS(8), .FRAMES(2)) u_b (
      .clk(clk), .reset(reset_n), .hole(hole_b), .clr(clr),
      .rpa(rpa_b), .rpb(rpb_b), .rb(rb_b), .rdone(rdone_b),
      .rcl(rcl_b), .busy(busy_b), .overrun(overrun_b), .count(count_b)
   );

   always @(negedge clk) begin
      if (rdone_a) rd_a++;
      if (rdone_b) rd_b++;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic feed(input bit b, input logic [7:0] f);
      if (b) hole_b = {1'b1, f};
      else   hole_a = {1'b1, f};
      tick(3);
      hole_a = '0;
      hole_b = '0;
      tick(3);
   endtask

   task automatic pulse_rpa(input bit b);
      if (b) rpa_b = 1'b1; else rpa_a = 1'b1;
      tick(1);
      rpa_a = 1'b0;
      rpa_b = 1'b0;
   endtask

   task automatic pulse_rpb(input bit b);
      if (b) rpb_b = 1'b1; else rpb_a = 1'b1;
      tick(1);
      rpb_a = 1'b0;
      rpb_b = 1'b0;
   endtask

   task automatic do_clr();
      clr = 1'b1;
      tick(1);
      clr = 1'b0;
      tick(1);
   endtask

   task automatic wait_rd(input bit b, input int base, input int maxc,
                          output bit ok);
      ok = 1'b0;
      for (int i = 0; i < maxc && !ok; i++) begin
         tick(1);
         if ((b ? rd_b : rd_a) > base) ok = 1'b1;
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      clr = 1'b0;
      hole_a = '0; hole_b = '0;
      rpa_a = 0; rpb_a = 0; rpa_b = 0; rpb_b = 0;
      tick(3);
      reset_n = 1'b1;
      tick(1);
      checks++; if (rb_a !== 18'd0) begin errors++; $display("FAIL reset_rb got %o want 0", rb_a); end
      checks++; if (rdone_a !== 1'b0) begin errors++; $display("FAIL reset_rdone got %b want 0", rdone_a); end
      checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_a); end
      checks++; if (overrun_a !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", overrun_a); end
      checks++; if (count_a !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count_a); end
      checks++; if (rcl_a !== 1'b1) begin errors++; $display("FAIL reset_rcl got %b want 1", rcl_a); end
   endtask

   task automatic test_alpha();
      int base;
      bit ok;
      feed(0, 8'o215);
      checks++; if (count_a !== 3'd1) begin errors++; $display("FAIL alpha_count got %0d want 1", count_a); end
      base = rd_a;
      pulse_rpa(0);
      wait_rd(0, base, 20, ok);
      checks++; if (!ok) begin errors++; $display("FAIL alpha_timeout got no rdone want rdone"); end
      checks++; if (rb_a !== 18'o000215) begin errors++; $display("FAIL alpha_rb got %o want 000215", rb_a); end
      tick(6);
      checks++; if (rd_a !== base + 1) begin errors++; $display("FAIL alpha_pulses got %0d want 1", rd_a - base); end
      checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL alpha_busy got %b want 0", busy_a); end
   endtask

   task automatic test_binary();
      logic [7:0]  fr [4];
      logic [17:0] exp;
      int base;
      bit ok;
      fr = '{8'o001, 8'o207, 8'o212, 8'o203};
      exp = '0;
      foreach (fr[i]) begin
         feed(0, fr[i]);
         if (fr[i][7]) exp = (exp << 6) | 18'(fr[i][5:0]);
      end
      checks++; if (overrun_a !== 1'b0) begin errors++; $display("FAIL bin_overrun got %b want 0", overrun_a); end
      base = rd_a;
      pulse_rpb(0);
      wait_rd(0, base, 20, ok);
      checks++; if (!ok) begin errors++; $display("FAIL bin_timeout got no rdone want rdone"); end
      checks++; if (rb_a !== exp) begin errors++; $display("FAIL bin_rb got %o want %o", rb_a, exp); end
      tick(6);
      checks++; if (rd_a !== base + 1) begin errors++; $display("FAIL bin_pulses got %0d want 1", rd_a - base); end
      checks++; if (count_a !== 3'd0) begin errors++; $display("FAIL bin_count got %0d want 0", count_a); end
   endtask

   task automatic test_random();
      logic [7:0]  f;
      logic [17:0] exp;
      int base, n;
      for (int it = 0; it < 10; it++) begin
         base = rd_a;
         if ($urandom_range(1) == 1) begin
            exp = '0;
            n = 0;
            pulse_rpb(0);
            while (n < 3) begin
               f = 8'($urandom);
               if (f[7]) begin
                  n++;
                  exp = (exp << 6) | 18'(f[5:0]);
               end
               feed(0, f);
               if (n < 3 && $urandom_range(1) == 1) pulse_rpa(0);
            end
         end else begin
            f = 8'($urandom);
            exp = 18'(f);
            if ($urandom_range(1) == 1) begin
               pulse_rpa(0);
               feed(0, f);
            end else begin
               feed(0, f);
               pulse_rpa(0);
            end
         end
         tick(6);
         checks++; if (rd_a !== base + 1) begin errors++; $display("FAIL rand_pulses it %0d got %0d want 1", it, rd_a - base); end
         checks++; if (rb_a !== exp) begin errors++; $display("FAIL rand_rb it %0d got %o want %o", it, rb_a, exp); end
         checks++; if (busy_a !== 1'b0 || count_a !== 3'd0) begin errors++; $display("FAIL rand_idle it %0d got busy %b count %0d want 0 0", it, busy_a, count_a); end
      end
   endtask

   task automatic test_overflow();
      logic [7:0] q [$];
      logic [7:0] f;
      bit ovr;
      int base;
      bit ok;
      do_clr();
      ovr = 1'b0;
      for (int i = 0; i < 6; i++) begin
         f = 8'($urandom);
         feed(0, f);
         if (q.size() < 4) q.push_back(f);
         else ovr = 1'b1;
         checks++; if (count_a !== 3'(q.size())) begin errors++; $display("FAIL ovf_count frame %0d got %0d want %0d", i, count_a, q.size()); end
         checks++; if (overrun_a !== ovr) begin errors++; $display("FAIL ovf_overrun frame %0d got %b want %b", i, overrun_a, ovr); end
         checks++; if (rcl_a !== (q.size() < 3)) begin errors++; $display("FAIL ovf_rcl frame %0d got %b want %b", i, rcl_a, q.size() < 3); end
      end
      base = rd_a;
      pulse_rpa(0);
      wait_rd(0, base, 20, ok);
      checks++; if (!ok || rb_a !== 18'(q[0])) begin errors++; $display("FAIL ovf_oldest got %o want %o", rb_a, q[0]); end
      checks++; if (overrun_a !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", overrun_a); end
      do_clr();
      checks++; if (overrun_a !== 1'b0 || count_a !== 3'd0) begin errors++; $display("FAIL ovf_clr got ovr %b count %0d want 0 0", overrun_a, count_a); end
   endtask

   task automatic test_simul();
      logic [7:0]  fr [4];
      logic [7:0]  first;
      logic [17:0] exp;
      int base;
      bit ok;
      do_clr();
      base = rd_a;
      rpa_a = 1'b1;
      rpb_a = 1'b1;
      tick(1);
      rpa_a = 1'b0;
      rpb_a = 1'b0;
      fr = '{8'o215, 8'o301, 8'o142, 8'o277};
      exp = '0;
      feed(0, fr[0]);
      exp = (exp << 6) | 18'(fr[0][5:0]);
      tick(4);
      checks++; if (rd_a !== base || busy_a !== 1'b1) begin errors++; $display("FAIL simul_mode got rdones %0d busy %b want 0 1", rd_a - base, busy_a); end
      for (int i = 1; i < 4; i++) begin
         feed(0, fr[i]);
         if (fr[i][7]) exp = (exp << 6) | 18'(fr[i][5:0]);
      end
      wait_rd(0, base, 20, ok);
      checks++; if (!ok || rb_a !== exp) begin errors++; $display("FAIL simul_rb got %o want %o", rb_a, exp); end
      do_clr();
      first = 8'($urandom);
      feed(0, first);
      for (int i = 0; i < 3; i++) feed(0, 8'($urandom));
      checks++; if (count_a !== 3'd4) begin errors++; $display("FAIL pp_prefill got %0d want 4", count_a); end
      base = rd_a;
      hole_a = {1'b1, 8'($urandom)};
      tick(1);
      rpa_a = 1'b1;
      tick(1);
      rpa_a = 1'b0;
      tick(1);
      checks++; if (count_a !== 3'd4 || overrun_a !== 1'b0) begin errors++; $display("FAIL pp_count got count %0d ovr %b want 4 0", count_a, overrun_a); end
      hole_a = '0;
      tick(5);
      checks++; if (rd_a !== base + 1 || rb_a !== 18'(first)) begin errors++; $display("FAIL pp_rb got %o want %o", rb_a, first); end
      checks++; if (count_a !== 3'd4 || overrun_a !== 1'b0) begin errors++; $display("FAIL pp_after got count %0d ovr %b want 4 0", count_a, overrun_a); end
      do_clr();
   endtask

   task automatic test_reset_mid();
      int base;
      base = rd_a;
      pulse_rpb(0);
      feed(0, 8'o255);
      feed(0, 8'o307);
      checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL rmid_busy got %b want 1", busy_a); end
      reset_n = 1'b0;
      tick(1);
      reset_n = 1'b1;
      tick(1);
      checks++; if (rb_a !== 18'd0 || busy_a !== 1'b0) begin errors++; $display("FAIL rmid_state got rb %o busy %b want 0 0", rb_a, busy_a); end
      checks++; if (rcl_a !== 1'b1 || count_a !== 3'd0) begin errors++; $display("FAIL rmid_fifo got rcl %b count %0d want 1 0", rcl_a, count_a); end
      tick(8);
      checks++; if (rd_a !== base) begin errors++; $display("FAIL rmid_rdone got %0d want 0", rd_a - base); end
      pulse_rpb(0);
      feed(0, 8'o211);
      feed(0, 8'o233);
      clr = 1'b1;
      tick(1);
      clr = 1'b0;
      tick(1);
      checks++; if (rb_a !== 18'd0 || busy_a !== 1'b0 || count_a !== 3'd0) begin errors++; $display("FAIL cmid_state got rb %o busy %b count %0d want 0 0 0", rb_a, busy_a, count_a); end
      tick(8);
      checks++; if (rd_a !== base) begin errors++; $display("FAIL cmid_rdone got %0d want 0", rd_a - base); end
   endtask

   task automatic test_sweep();
      logic [7:0]  fr [3];
      logic [15:0] exp;
      int base;
      bit ok;
      fr = '{8'o001, 8'o377, 8'o201};
      exp = '0;
      base = rd_b;
      pulse_rpb(1);
      foreach (fr[i]) begin
         feed(1, fr[i]);
         if (fr[i][7]) exp = (exp << 8) | 16'(fr[i]);
      end
      wait_rd(1, base, 20, ok);
      checks++; if (!ok || rb_b !== exp) begin errors++; $display("FAIL sweep_rb got %h want %h", rb_b, exp); end
      tick(6);
      checks++; if (rd_b !== base + 1 || busy_b !== 1'b0) begin errors++; $display("FAIL sweep_done got %0d busy %b want 1 0", rd_b - base, busy_b); end
   endtask

   initial begin
      test_reset();
      test_alpha();
      test_binary();
      test_random();
      test_overflow();
      test_simul();
      test_reset_mid();
      test_sweep();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ptr_reader.md
PTR_READER -- requirements
Module: ptr_reader

Interface
REQ-001 SHALL have parameter WORD_W, default 18: width of assembled word rb.
REQ-002 SHALL have parameter FRAME_BITS, default 6: data bits per binary frame (holes FRAME_BITS..1).
REQ-003 SHALL have parameter FRAMES, default 3: binary frames per word; FRAMES*FRAME_BITS <= WORD_W.
REQ-004 SHALL have parameter DEPTH, default 4, power of 2 >= 2: read-ahead frame FIFO depth.
REQ-005 SHALL have parameter PREFETCH, default 1: 1 = clutch may run while idle to fill FIFO.
REQ-006 SHALL have ports: clk  input  1  sole clock, all state on rising edge.
REQ-007 reset  input  1  asynchronous active-low reset (0 = reset).
REQ-008 hole  input  9  tape sense, hole[9] feed hole, hole[8:1] data, asynchronous to clk.
REQ-009 clr  input  1  synchronous clear, one-cycle pulse (power clear).
REQ-010 rpa  input  1  one-cycle pulse, alphanumeric read request.
REQ-011 rpb  input  1  one-cycle pulse, binary read request.
REQ-012 rb  output  WORD_W  assembled reader buffer.
REQ-013 rdone  output  1  one-cycle pulse, word complete (reader return).
REQ-014 rcl  output  1  reader clutch, 1 = tape moving.
REQ-015 busy  output  1  state != IDLE.
REQ-016 overrun  output  1  sticky, frame lost on full FIFO.
REQ-017 count  output  $clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-018 hole SHALL pass through a 2-flop synchroniser; a frame event SHALL be a 0->1 transition of synchronised hole[9].
REQ-019 On a frame event, synchronised hole[8:1] SHALL be pushed into the FIFO if count < DEPTH or a pop occurs in the same cycle; otherwise it SHALL be dropped and overrun set.
REQ-020 rcl SHALL be 1 when count < DEPTH-1 and (busy or PREFETCH==1); else 0; combinational from registered state.
REQ-021 FSM states SHALL be IDLE, ALPHA, BIN, DONE.
REQ-022 IDLE + rpb: rb <= 0, frame counter k <= 0, go BIN; rpb SHALL win if rpa and rpb coincide.
REQ-023 IDLE + rpa (no rpb): rb <= 0, go ALPHA.
REQ-024 rpa/rpb outside IDLE SHALL be ignored.
REQ-025 ALPHA with count>0: pop; rb <= zero-extended frame[8:1]; go DONE.
REQ-026 BIN with count>0: pop; frame with bit 8 = 0 SHALL be discarded (k unchanged); frame with bit 8 = 1: rb <= (rb << FRAME_BITS) | frame[FRAME_BITS:1] truncated to WORD_W, k <= k+1; go DONE when k+1 == FRAMES.
REQ-027 ALPHA/BIN with count==0 SHALL wait without timeout.
REQ-028 DONE SHALL assert rdone for exactly that one cycle and return to IDLE next edge.
REQ-029 Latency: frame already buffered, rpa at edge N -> pop at N+1 -> rdone high during cycle after N+2 edge; rb stable from that cycle until next accepted rpa/rpb.
REQ-030 FIFO SHALL be wrap-around circular with pointers one bit wider than log2(DEPTH); simultaneous push and pop SHALL keep count unchanged.
REQ-031 clr SHALL flush FIFO (count 0), go IDLE, clear overrun and rb, suppress rdone; clr overrides rpa/rpb and frame events in the same cycle.

Reset
REQ-032 reset low SHALL asynchronously force: state IDLE, rb 0, rdone 0, overrun 0, count 0, pointers 0, k 0, synchroniser flops 0.
REQ-033 Reset mid-word SHALL discard partial assembly; no rdone after release.
REQ-034 After release, rcl SHALL equal PREFETCH (FIFO empty, idle).

Structure
REQ-035 FSM state enum and frame-bit index constants (FEED=9, BINFLAG=8) SHALL live in shared package pdp1_pkg.
REQ-036 FIFO SHALL be one sub-module, frame_fifo, parametrised by DEPTH, width 8.
REQ-037 Edge detection SHALL be inline, not a new module.

Verification
REQ-038 Alpha: frame 8'o215 fed, rpa -> rb = 18'o000215, single rdone pulse, busy 0 after.
REQ-039 Binary: frames 8'o001, 8'o207, 8'o212, 8'o203 fed, rpb -> first frame skipped, rb = 18'o071203, one rdone.
REQ-040 Overflow: PREFETCH=1, DEPTH=4, 6 frames no requests -> rcl drops at count 3, count = 4, overrun = 1 after 5th frame.
REQ-041 Simultaneity: rpa+rpb same cycle -> binary mode; push+pop at count 4 -> count stays 4, overrun stays 0.
REQ-042 Reset mid-word: rpb, 2 binary frames, reset low 1 cycle -> rb 0, IDLE, no rdone; clr mid-word likewise.
REQ-043 Parameter sweep: FRAMES=2, FRAME_BITS=8, WORD_W=16, frames 8'o377,8'o001 with bit 8 forced per REQ-026 -> rb width/shift correct.
